// File: rtl/overlay_pkg.sv
// Shared types and constants for the prompt-overlay scheduler: FSM states,
// requester indices, backdrop group masks and default VGA frame geometry.
package overlay_pkg;

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   localparam int REQ_Q1 = 0;
   localparam int REQ_Q2 = 1;
   localparam int REQ_Q3 = 2;
   localparam int REQ_G1 = 3;
   localparam int REQ_G2 = 4;
   localparam int REQ_G3 = 5;

   localparam logic [5:0] QUIZ_MASK = 6'b000111;
   localparam logic [5:0] GAME_MASK = 6'b111000;

   localparam int VGA_H_TOTAL = 800;
   localparam int VGA_V_TOTAL = 525;

   // Width of a down-counter that must hold n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/overlay_scheduler_frame_edge_det.sv
// Frame-boundary detector: flags the last pixel of the last line and emits a
// single-clock frame_start on the first clock of that (multi-clock) tick.
module frame_edge_det
   import overlay_pkg::*;
#(
   parameter int H_TOTAL = VGA_H_TOTAL,
   parameter int V_TOTAL = VGA_V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] h_count_i,
   input  logic [9:0] v_count_i,
   output logic       frame_start_o
);

   logic tick;
   logic tick_q;

   assign tick = (h_count_i == 10'(H_TOTAL - 1)) && (v_count_i == 10'(V_TOTAL - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tick_q <= 1'b0;
      else     tick_q <= tick;
   end

   // Held low during reset so no boundary is reported while the FSM is cleared.
   assign frame_start_o = tick & ~tick_q & ~rst;

endmodule

// File: rtl/overlay_scheduler.sv
// Frame-aligned overlay arbiter with minimum hold and blank gap between overlays.
// Optional blink of the granted overlay is enabled by defining OVERLAY_BLINK_EN.
module overlay_scheduler
   import overlay_pkg::*;
#(
   parameter int H_TOTAL         = VGA_H_TOTAL,
   parameter int V_TOTAL         = VGA_V_TOTAL,
   parameter int N_REQ           = 6,
   parameter int MIN_HOLD_FRAMES = 30,
   parameter int GAP_FRAMES      = 2,
   parameter int BLINK_FRAMES    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [9:0]       hCount,
   input  logic [9:0]       vCount,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             quiz_bg_en,
   output logic             game_bg_en,
   output logic             busy,
   output logic             frame_start
);

   localparam int HOLD_W = cnt_w(MIN_HOLD_FRAMES);
   localparam int GAP_W  = cnt_w(GAP_FRAMES);
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(MIN_HOLD_FRAMES - 1);
   localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(GAP_FRAMES - 1);

   if (MIN_HOLD_FRAMES < 1 || GAP_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_param
      $error("overlay_scheduler: frame counts must all be at least 1");
   end

   state_t             state_q;
   logic [N_REQ-1:0]   grant_q;
   logic [HOLD_W-1:0]  hold_q;
   logic [GAP_W-1:0]   gap_q;
   logic               quiz_q;
   logic               game_q;
   logic               busy_q;
   logic [N_REQ-1:0]   winner;
   logic               fs;

   frame_edge_det #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_edge (
      .clk           (clk),
      .rst           (rst),
      .h_count_i     (hCount),
      .v_count_i     (vCount),
      .frame_start_o (fs)
   );

   // Isolate the lowest set bit: index 0 (Q1) has the highest priority.
   assign winner = req & (~req + N_REQ'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         hold_q  <= '0;
         gap_q   <= '0;
         quiz_q  <= 1'b0;
         game_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else if (fs) begin
         unique case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q <= SHOW;
                  grant_q <= winner;
                  hold_q  <= HOLD_RELOAD;
                  quiz_q  <= |(winner & QUIZ_MASK);
                  game_q  <= |(winner & GAME_MASK);
                  busy_q  <= 1'b1;
               end
            end
            SHOW: begin
               if (hold_q != '0) begin
                  hold_q <= hold_q - 1'b1;
               end else if (winner != grant_q) begin
                  // Covers both a dropped request and a change of winner.
                  state_q <= GAP;
                  grant_q <= '0;
                  quiz_q  <= 1'b0;
                  game_q  <= 1'b0;
                  gap_q   <= GAP_RELOAD;
               end
            end
            GAP: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else if (|req) begin
                  state_q <= SHOW;
                  grant_q <= winner;
                  hold_q  <= HOLD_RELOAD;
                  quiz_q  <= |(winner & QUIZ_MASK);
                  game_q  <= |(winner & GAME_MASK);
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef OVERLAY_BLINK_EN
   localparam int BLINK_W = cnt_w(BLINK_FRAMES);
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_phase_q;

   // Phase restarts visible on every entry to SHOW; outside SHOW it is don't-care.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else if (fs) begin
         if (state_q != SHOW) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
         end else if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   assign grant = blink_phase_q ? grant_q : '0;
`else
   assign grant = grant_q;
`endif

   assign quiz_bg_en  = quiz_q;
   assign game_bg_en  = game_q;
   assign busy        = busy_q;
   assign frame_start = fs;

endmodule

// File: tb/tb_overlay_scheduler.sv
// Scoreboard bench for overlay_scheduler on a shrunken VGA raster: a frame-level
// reference model queues expected outputs, a monitor checks them every cycle.
module tb_overlay_scheduler;
   localparam int H       = 16;
   localparam int V       = 8;
   localparam int PIX_DIV = 2;
   localparam int HOLD    = 3;
   localparam int GAPF    = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] hCount = '0;
   logic [9:0] vCount = '0;
   logic [5:0] req = '0;
   logic [5:0] grant;
   logic       quiz_bg_en, game_bg_en, busy, frame_start;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [5:0] grant;
      logic       qbg;
      logic       gbg;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur_exp = '0;

   overlay_scheduler #(
      .H_TOTAL(H), .V_TOTAL(V), .N_REQ(6),
      .MIN_HOLD_FRAMES(HOLD), .GAP_FRAMES(GAPF), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount), .req(req),
      .grant(grant), .quiz_bg_en(quiz_bg_en), .game_bg_en(game_bg_en),
      .busy(busy), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // VGA raster: one pixel every PIX_DIV clocks, updated away from the clock edge.
   int pix_ph = 0;
   initial forever begin
      @(posedge clk); #2;
      pix_ph++;
      if (pix_ph == PIX_DIV) begin
         pix_ph = 0;
         if (hCount == 10'(H - 1)) begin
            hCount = '0;
            vCount = (vCount == 10'(V - 1)) ? 10'd0 : vCount + 10'd1;
         end else begin
            hCount = hCount + 10'd1;
         end
      end
   end

   // Reference model, one step per frame: mode 0 = nothing shown, 1 = showing, 2 = blank.
   int m_mode = 0, m_idx = -1, m_shown = 0, m_blank = 0, frame_no = 0;
   logic m_tick_d = 1'b0, m_tk;

   function automatic int winner_of(input logic [5:0] r);
      for (int i = 0; i < 6; i++) if (r[i]) return i;
      return -1;
   endfunction

   task automatic model_frame(input logic [5:0] r);
      int w;
      w = winner_of(r);
      case (m_mode)
         0: if (w >= 0) begin m_mode = 1; m_idx = w; m_shown = 1; end
         1: begin
            if (m_shown < HOLD) m_shown++;
            else if (w != m_idx) begin m_mode = 2; m_idx = -1; m_blank = 1; end
         end
         default: begin
            if (m_blank < GAPF) m_blank++;
            else if (w >= 0) begin m_mode = 1; m_idx = w; m_shown = 1; end
            else m_mode = 0;
         end
      endcase
   endtask

   function automatic exp_t expect_now();
      exp_t e;
      e.grant = (m_idx >= 0) ? (6'b000001 << m_idx) : 6'b0;
      e.qbg   = (m_idx >= 0) && (m_idx <= 2);
      e.gbg   = (m_idx >= 3);
      e.busy  = (m_mode != 0);
      return e;
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_tick_d = 1'b0; m_mode = 0; m_idx = -1;
         exp_q.delete();
      end else begin
         m_tk = (hCount == 10'(H - 1)) && (vCount == 10'(V - 1));
         if (m_tk && !m_tick_d) begin
            model_frame(req);
            exp_q.push_back(expect_now());
            frame_no++;
         end
         m_tick_d = m_tk;
      end
   end

   // Monitor: frame_start shape, pops after each DUT frame_start, per-cycle output check.
   logic fs_seen = 1'b0, mon_tick_prev = 1'b0, mon_tk, exp_fs;
   initial forever begin
      @(negedge clk);
      mon_tk = (hCount == 10'(H - 1)) && (vCount == 10'(V - 1));
      exp_fs = mon_tk && !mon_tick_prev && !rst;
      mon_tick_prev = rst ? 1'b0 : mon_tk;
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      if (rst) begin
         fs_seen = 1'b0;
         cur_exp = '0;
      end else if (fs_seen) begin
         if (exp_q.size() == 0) chk("scoreboard_underrun", 32'(1), 32'(0));
         else cur_exp = exp_q.pop_front();
      end
      chk("outputs{grant,qbg,gbg,busy}",
          32'({grant, quiz_bg_en, game_bg_en, busy}), 32'(cur_exp));
      chk("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
      chk("bg_exclusive", 32'(quiz_bg_en && game_bg_en), 32'(0));
      fs_seen = frame_start && !rst;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_frames(input int n);
      int target, cyc;
      target = frame_no + n;
      cyc = 0;
      while (frame_no < target && cyc < 300 * n + 300) begin
         @(posedge clk);
         cyc++;
      end
      #2;
      if (frame_no < target) chk("frame_timeout", 32'(frame_no), 32'(target));
   endtask

   task automatic go_idle();
      req = '0;
      wait_frames(HOLD + GAPF + 2);
      cycles(1);
      chk("idle_busy", 32'(busy), 32'(0));
   endtask

   logic [5:0] base;
   initial begin
      cycles(5);
      chk("reset_grant", 32'(grant), 32'(0));
      chk("reset_busy", 32'({quiz_bg_en, game_bg_en, busy}), 32'(0));
      rst = 1'b0;

      // Reset in the middle of SHOW aborts at once, then re-grants next frame.
      req = 6'b000001;
      wait_frames(1); cycles(100);
      wait_frames(1); cycles(100);
      chk("pre_reset_grant", 32'(grant), 32'h01);
      rst = 1'b1; #1;
      chk("async_reset_grant", 32'(grant), 32'(0));
      chk("async_reset_busy", 32'(busy), 32'(0));
      cycles(3); rst = 1'b0;
      wait_frames(1); cycles(1);
      chk("regrant_after_reset", 32'(grant), 32'h01);
      go_idle();

      // Mid-frame request waits for the boundary.
      cycles(100);
      req = 6'b001000;
      cycles(10);
      chk("no_grant_mid_frame", 32'(grant), 32'(0));
      wait_frames(1); cycles(1);
      chk("frame_aligned_grant", 32'(grant), 32'h08);
      chk("game_bg", 32'({quiz_bg_en, game_bg_en}), 32'b01);
      go_idle();

      // Minimum hold then one blank frame then idle.
      req = 6'b000010;
      wait_frames(1); cycles(100);
      wait_frames(1); cycles(100);
      req = '0;
      wait_frames(1); cycles(1);
      chk("hold_third_frame", 32'(grant), 32'h02);
      wait_frames(1); cycles(1);
      chk("gap_frame", 32'({grant, busy}), 32'({6'b0, 1'b1}));
      wait_frames(1); cycles(1);
      chk("back_to_idle", 32'(busy), 32'(0));

      // Higher priority arrives during hold: no preemption until hold and gap expire.
      req = 6'b000100;
      wait_frames(1); cycles(100);
      req = 6'b000101;
      wait_frames(1); cycles(1);
      chk("no_preempt", 32'(grant), 32'h04);
      wait_frames(2); cycles(1);
      chk("preempt_gap", 32'(grant), 32'(0));
      wait_frames(1); cycles(1);
      chk("preempt_grant", 32'(grant), 32'h01);
      go_idle();

      // Simultaneous requests from idle.
      req = 6'b110100;
      wait_frames(1); cycles(1);
      chk("simul_grant", 32'(grant), 32'h04);
      chk("quiz_bg", 32'({quiz_bg_en, game_bg_en}), 32'b10);
      go_idle();

      // Random frames with mid-frame glitches that must be ignored.
      for (int f = 0; f < 60; f++) begin
         base = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom);
         wait_frames(1); cycles(2);
         req = base;
         cycles($urandom_range(20, 180));
         req = 6'($urandom);
         cycles($urandom_range(1, 20));
         req = base;
         if (f == 30) begin
            rst = 1'b1; #1;
            chk("random_reset_grant", 32'({grant, busy}), 32'(0));
            cycles(3); rst = 1'b0;
         end
      end
      go_idle();
      cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
